motor_pwm_capture: RTL and testbench
====================================

Name: motor_pwm_capture

Overview:
- Receive-side counterpart of the motor PWM drive path.
- Watches one motor channel's fwd/rev PWM lines, measures high-time over each fixed PWM period window, and reconstructs the signed (PW+1)-bit drive command plus brake/fault status.
- Used for closed-loop self-check of the motor controller and by the bench as a monitor.
- One instance per motor (left, right).

Parameters:
- PW, 10, PWM counter width; window length = 2^PW clocks; cmd width = PW+1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- clr  input  1  synchronous window restart; discards partial window, no cmd_vld
- fwd  input  1  forward PWM line
- rev  input  1  reverse PWM line
- cmd  output PW+1  reconstructed signed command, two's complement
- cmd_vld  output 1  one-cycle pulse when cmd/brake/fault update
- brake  output 1  last window had both lines high the entire window
- fault  output 1  last window had both fwd and rev active, but not full brake

Behaviour:
- Reset (rst=1 at clk edge): cmd=0, cmd_vld=0, brake=0, fault=0, window counter=0, fwd_acc=0, rev_acc=0.
- Window counter win_cnt (PW bits) increments every cycle and wraps 2^PW-1 -> 0.
- Accumulators:
  - fwd_acc and rev_acc are PW+1 bits, range 0..2^PW.
  - Each adds 1 on every cycle its line is 1, including the cycle where win_cnt = 2^PW-1.
- End of window (win_cnt = 2^PW-1):
  - Decode uses the accumulator values including the current sample: F = fwd_acc + fwd, R = rev_acc + rev.
  - Results register at that edge; cmd_vld=1 for exactly the next cycle.
  - Accumulators reload to 0 at the same edge.
- Decode priority:
  1. F = 2^PW and R = 2^PW: brake=1, fault=0, cmd=0.
  2. F = 0 and R = 0: cmd=0 (coast), brake=0, fault=0.
  3. R = 0: cmd = +min(F, 2^PW-1), brake=0, fault=0.
  4. F = 0: cmd = -min(R, 2^PW-1), brake=0, fault=0.
  5. Otherwise: fault=1, brake=0, cmd holds its previous value.
- Saturation: full-high magnitude 2^PW clamps to 2^PW-1. The most negative cmd produced is -(2^PW-1); the value -2^PW is never output.
- Outputs between cmd_vld pulses hold their last values.
- clr:
  - Zeroes win_cnt and both accumulators; outputs hold; no cmd_vld that cycle.
  - clr coincident with end of window: clr wins; no update, no pulse.
  - rst has priority over clr.
- Latency: cmd_vld rises 2^PW cycles after rst/clr deassertion (first full window); the sample on the clr-release edge is counted.
- Reset mid-window: partial window discarded; behaves as from power-up.

Optional Feature:
- Macro: MOTOR_PWM_CAPTURE_SYNC_EN.
- Defined:
  - fwd and rev each pass through a 2-flop synchronizer (flops reset to 0) before accumulation.
  - The measured window is shifted by 2 cycles relative to the raw lines; all decode rules are unchanged.
- Undefined: fwd/rev sampled directly (same-clock source assumed); no extra latency.

Test Plan (PW=10):
- fwd high 300 cycles within a window, rev=0 -> cmd=11'h12C, brake=0, fault=0, cmd_vld single-cycle pulse one cycle after win_cnt=1023.
- rev high 1 cycle, fwd=0 -> cmd=11'h7FF (-1); fwd=1 all 1024 cycles, rev=0 -> cmd=11'h3FF (saturated +1023).
- fwd=rev=1 all 1024 cycles -> brake=1, cmd=11'h000, fault=0; next window fwd=rev=0 -> brake=0, cmd=0.
- Window with cmd=+300 then window with fwd 10 cycles and rev 10 cycles -> fault=1, cmd stays 11'h12C.
- rst asserted at win_cnt=500 for 3 cycles -> all outputs 0; first cmd_vld exactly 1024 cycles after rst falls.
- clr pulsed at win_cnt=1023 -> no cmd_vld that window; accumulators restart; next pulse 1024 cycles after clr release.

Source files
------------

// File: rtl/motor_pwm_capture_if.sv
// ============================================================================
// Module      : motor_pwm_capture_if
// Description : Signal bundle between a motor PWM channel and its capture
//               block: window restart, raw fwd/rev lines, and the decoded
//               command/status returned by the capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motor_pwm_capture_if #(
  parameter int PW = 10
);
  logic          clr;
  logic          fwd;
  logic          rev;
  logic [PW:0]   cmd;
  logic          cmd_vld;
  logic          brake;
  logic          fault;

  // Driver side: owns the PWM lines and the restart, observes the decode
  modport master (
    output clr, fwd, rev,
    input  cmd, cmd_vld, brake, fault
  );

  // Capture side: observes the PWM lines, returns the decode
  modport slave (
    input  clr, fwd, rev,
    output cmd, cmd_vld, brake, fault
  );
endinterface

`default_nettype wire

// File: rtl/motor_pwm_capture.sv
// ============================================================================
// Module      : motor_pwm_capture
// Description : Measures fwd/rev PWM high-time over fixed 2^PW-clock windows
//               and rebuilds the signed (PW+1)-bit drive command plus
//               brake/fault status. Optional macro MOTOR_PWM_CAPTURE_SYNC_EN
//               adds a 2-flop synchronizer on each PWM line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_pwm_capture #(
  parameter int PW = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  motor_pwm_capture_if.slave    bus
);

  localparam logic [PW:0]   c_full = {1'b1, {PW{1'b0}}};
  localparam logic [PW-1:0] c_one  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] c_max  = {PW{1'b1}};

  logic          w_fwd;
  logic          w_rev;
  logic [PW-1:0] r_win_cnt;
  logic [PW:0]   r_fwd_acc;
  logic [PW:0]   r_rev_acc;
  logic [PW:0]   r_cmd;
  logic          r_cmd_vld;
  logic          r_brake;
  logic          r_fault;

`ifdef MOTOR_PWM_CAPTURE_SYNC_EN
  logic [1:0] r_fwd_sync;
  logic [1:0] r_rev_sync;

  // Two-stage synchronizer on each asynchronous PWM line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sync <= 2'b00;
      r_rev_sync <= 2'b00;
    end else begin
      r_fwd_sync <= {r_fwd_sync[0], bus.fwd};
      r_rev_sync <= {r_rev_sync[0], bus.rev};
    end
  end

  assign w_fwd = r_fwd_sync[1];
  assign w_rev = r_rev_sync[1];
`else
  assign w_fwd = bus.fwd;
  assign w_rev = bus.rev;
`endif

  // Totals including the current sample, so the last cycle of a window counts
  logic [PW:0]   w_f;
  logic [PW:0]   w_r;
  logic [PW-1:0] w_fmag;
  logic [PW-1:0] w_rmag;
  logic          w_end;

  assign w_f    = r_fwd_acc + {{PW{1'b0}}, w_fwd};
  assign w_r    = r_rev_acc + {{PW{1'b0}}, w_rev};
  // A full-high window (2^PW) clamps so the negative range stays symmetric
  assign w_fmag = w_f[PW] ? c_max : w_f[PW-1:0];
  assign w_rmag = w_r[PW] ? c_max : w_r[PW-1:0];
  assign w_end  = (r_win_cnt == c_max);

  logic [PW:0] w_nxt_cmd;
  logic        w_nxt_brake;
  logic        w_nxt_fault;

  // Window decode in priority order: brake, coast, forward, reverse, fault
  always_comb begin
    w_nxt_cmd   = r_cmd;
    w_nxt_brake = 1'b0;
    w_nxt_fault = 1'b0;
    if (w_f == c_full && w_r == c_full) begin
      w_nxt_brake = 1'b1;
      w_nxt_cmd   = '0;
    end else if (w_f == '0 && w_r == '0) begin
      w_nxt_cmd   = '0;
    end else if (w_r == '0) begin
      w_nxt_cmd   = {1'b0, w_fmag};
    end else if (w_f == '0) begin
      w_nxt_cmd   = -{1'b0, w_rmag};
    end else begin
      w_nxt_fault = 1'b1;
    end
  end

  // Window counter, accumulators and registered decode results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_fwd_acc <= '0;
      r_rev_acc <= '0;
      r_cmd     <= '0;
      r_cmd_vld <= 1'b0;
      r_brake   <= 1'b0;
      r_fault   <= 1'b0;
    end else if (bus.clr) begin
      r_win_cnt <= '0;
      r_fwd_acc <= '0;
      r_rev_acc <= '0;
      r_cmd_vld <= 1'b0;
    end else begin
      r_win_cnt <= r_win_cnt + c_one;
      r_cmd_vld <= 1'b0;
      if (w_end) begin
        r_fwd_acc <= '0;
        r_rev_acc <= '0;
        r_cmd     <= w_nxt_cmd;
        r_brake   <= w_nxt_brake;
        r_fault   <= w_nxt_fault;
        r_cmd_vld <= 1'b1;
      end else begin
        r_fwd_acc <= w_f;
        r_rev_acc <= w_r;
      end
    end
  end

  assign bus.cmd     = r_cmd;
  assign bus.cmd_vld = r_cmd_vld;
  assign bus.brake   = r_brake;
  assign bus.fault   = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_motor_pwm_capture.sv
// ============================================================================
// Module      : tb_motor_pwm_capture
// Description : Scoreboard bench for motor_pwm_capture (PW=10). Each directed
//               window pushes its expected decode and pulse cycle; a monitor
//               pops and compares on every cmd_vld.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_pwm_capture;

  localparam int PW  = 10;
  localparam int WIN = 1 << PW;

  typedef struct {
    logic [PW:0] cmd;
    logic        brake;
    logic        fault;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  motor_pwm_capture_if #(.PW(PW)) bus ();

  motor_pwm_capture #(.PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cmd_vld pulse must match the oldest expected window
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cmd_vld === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("cmd", int'(bus.cmd), int'(e.cmd));
          check("brake", int'(bus.brake), int'(e.brake));
          check("fault", int'(bus.fault), int'(e.fault));
        end
      end
    end
  end

  // Drive n cycles of constant levels without expecting a result
  task automatic drive_n(input int n, input logic f, input logic r);
    for (int i = 0; i < n; i++) begin
      bus.fwd = f;
      bus.rev = r;
      @(negedge clk);
    end
  endtask

  // One full window: fwd high for the first nf cycles, rev for the first nr
  task automatic window(input int nf, input int nr, input logic [PW:0] ecmd,
                        input logic eb, input logic ef);
    exp_t e;
    e.cmd   = ecmd;
    e.brake = eb;
    e.fault = ef;
    e.cyc   = cyc + WIN;
    sb.push_back(e);
    for (int i = 0; i < WIN; i++) begin
      bus.fwd = (i < nf);
      bus.rev = (i < nr);
      @(negedge clk);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cmd"}, int'(bus.cmd), 0);
    check({tag, "_vld"}, int'(bus.cmd_vld), 0);
    check({tag, "_brake"}, int'(bus.brake), 0);
    check({tag, "_fault"}, int'(bus.fault), 0);
  endtask

  initial begin
    cyc     = 0;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.clr = 1'b0;
    bus.fwd = 1'b0;
    bus.rev = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    rst = 1'b0;
    window(300,  0,    11'h12C, 1'b0, 1'b0);
    window(0,    1,    11'h7FF, 1'b0, 1'b0);
    window(1024, 0,    11'h3FF, 1'b0, 1'b0);
    window(1024, 1024, 11'h000, 1'b1, 1'b0);
    window(0,    0,    11'h000, 1'b0, 1'b0);
    window(300,  0,    11'h12C, 1'b0, 1'b0);
    window(10,   10,   11'h12C, 1'b0, 1'b1);
    window(0,    1024, 11'h401, 1'b0, 1'b0);
    window(1023, 0,    11'h3FF, 1'b0, 1'b0);
    window(1024, 1023, 11'h3FF, 1'b0, 1'b1);
    window(0,    0,    11'h000, 1'b0, 1'b0);

    // Reset partway through a window, after a result was registered
    window(0,    5,    11'h7FB, 1'b0, 1'b0);
    drive_n(500, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    window(5,    0,    11'h005, 1'b0, 1'b0);

    // clr on the last cycle of a window suppresses that window's result
    drive_n(1023, 1'b1, 1'b0);
    bus.clr = 1'b1;
    bus.fwd = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_hold_cmd", int'(bus.cmd), 11'h005);
    window(7,    0,    11'h007, 1'b0, 1'b0);

    // Allow the final pulse to be seen, bounded
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "time limit reached");
  end

endmodule

`default_nettype wire
